// File: rtl/datapath_pkg.sv
// Shared datapath types for the scalar writeback path: result words, register
// selects, writeback bundles and the per-source FIFO entry format.
package datapath_pkg;

   localparam int WORD_W       = 32;
   localparam int WB_ARB_DEPTH = 2;
   localparam int WB_NUM_SRC   = 3;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_JUMP = 2'd2
   } wb_arb_src_e;

   typedef struct packed {
      logic              spec;
      regbits_t          rd;
      logic [WORD_W-1:0] wdat;
   } wb_entry_t;

   typedef struct packed {
      logic              reg_en;
      regbits_t          reg_sel;
      logic [WORD_W-1:0] wdat;
   } wb_t;

   // Source k positions after s in ALU -> LOAD -> JUMP -> ALU order.
   function automatic wb_arb_src_e wb_rr_next(input wb_arb_src_e s, input int k);
      int v;
      v = (int'(s) + k) % WB_NUM_SRC;
      return wb_arb_src_e'(v[1:0]);
   endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source writeback FIFO. Speculative entries always sit as a contiguous
// tail suffix, so a mispredict flush only has to pull the tail back.
module wb_src_fifo
   import datapath_pkg::*;
#(
   parameter int DEPTH = WB_ARB_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  wb_entry_t                  push_ent,
   input  logic                       pop,
   input  logic                       resolve,
   input  logic                       miss_flush,
   output wb_entry_t                  head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     n_spec
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t         mem [DEPTH];
   logic [PW-1:0]     hd_ptr, tl_ptr, wr_ptr;
   logic              accept, do_pop;
   wb_entry_t         wr_ent;

   assign head = mem[hd_ptr];
   assign full = (count == CW'(DEPTH));

   always_comb begin
      n_spec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count && mem[hd_ptr + PW'(i)].spec)
            n_spec = n_spec + CW'(1);
      end
   end

   // Fullness is judged on registered state; a same-cycle pop never makes room.
   assign accept = push && !full && !(miss_flush && push_ent.spec);
   assign do_pop = pop && (count != '0);

   // A flush discards the speculative suffix, so a surviving push lands
   // right after the last non-speculative entry.
   assign wr_ptr = miss_flush ? (tl_ptr - n_spec[PW-1:0]) : tl_ptr;

   always_comb begin
      wr_ent      = push_ent;
      wr_ent.spec = push_ent.spec & ~resolve;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hd_ptr <= '0;
         tl_ptr <= '0;
         count  <= '0;
      end else begin
         if (resolve) begin
            for (int i = 0; i < DEPTH; i++)
               mem[i].spec <= 1'b0;
         end
         if (accept)
            mem[wr_ptr] <= wr_ent;
         if (do_pop)
            hd_ptr <= hd_ptr + PW'(1);
         tl_ptr <= wr_ptr + PW'(accept);
         count  <= count - (miss_flush ? n_spec : CW'(0)) - CW'(do_pop) + CW'(accept);
      end
   end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Round-robin arbiter sharing the scalar register-file write port between the
// ALU, load/store and jump-link completion FIFOs.
module scalar_wb_arbiter
   import datapath_pkg::*;
#(
   parameter int DEPTH = WB_ARB_DEPTH
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              alu_done,
   input  logic              load_done,
   input  logic              jump_done,
   input  logic [WORD_W-1:0] alu_wdat,
   input  logic [WORD_W-1:0] load_wdat,
   input  logic [WORD_W-1:0] jump_wdat,
   input  regbits_t          alu_reg_sel,
   input  regbits_t          load_reg_sel,
   input  regbits_t          jump_reg_sel,
   input  logic              spec,
   input  logic              bfu_resolved,
   input  logic              bfu_miss,
   output logic              alu_rdy,
   output logic              load_rdy,
   output logic              jump_rdy,
   output wb_t               wb,
   output logic              s_rw_en,
   output regbits_t          s_rw,
   output logic              overflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [WB_NUM_SRC-1:0]          push_v, pop_v, full_v, elig;
   wb_entry_t [WB_NUM_SRC-1:0]     push_ent, heads;
   logic [WB_NUM_SRC-1:0][CW-1:0]  cnt, nspec;
   logic                           resolve, gnt_vld, wr;
   wb_arb_src_e                    last_grant, gnt_src, cand;
   wb_entry_t                      gh;

   // Miss wins if both branch outcomes are ever seen together.
   assign resolve = bfu_resolved & ~bfu_miss;

   assign push_v           = {jump_done, load_done, alu_done};
   assign push_ent[WB_ALU]  = '{spec: spec, rd: alu_reg_sel,  wdat: alu_wdat};
   assign push_ent[WB_LOAD] = '{spec: spec, rd: load_reg_sel, wdat: load_wdat};
   assign push_ent[WB_JUMP] = '{spec: spec, rd: jump_reg_sel, wdat: jump_wdat};

   for (genvar g = 0; g < WB_NUM_SRC; g++) begin : g_src
      wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk        (CLK),
         .rst        (nRST),
         .push       (push_v[g]),
         .push_ent   (push_ent[g]),
         .pop        (pop_v[g]),
         .resolve    (resolve),
         .miss_flush (bfu_miss),
         .head       (heads[g]),
         .count      (cnt[g]),
         .full       (full_v[g]),
         .n_spec     (nspec[g])
      );
      // count > n_spec means a non-speculative entry exists, and with the
      // suffix invariant that entry is the head.
      assign elig[g] = (cnt[g] > nspec[g]) && !heads[g].spec;
   end

   assign {jump_rdy, load_rdy, alu_rdy} = ~full_v;

   always_comb begin
      gnt_vld = 1'b0;
      gnt_src = last_grant;
      cand    = last_grant;
      for (int k = 1; k <= WB_NUM_SRC; k++) begin
         cand = wb_rr_next(last_grant, k);
         if (!gnt_vld && elig[cand]) begin
            gnt_vld = 1'b1;
            gnt_src = cand;
         end
      end
   end

   assign pop_v = gnt_vld ? (WB_NUM_SRC'(1) << gnt_src) : '0;
   assign gh    = heads[gnt_src];

   // x0 entries drain like any other but never reach the register file.
   assign wr         = gnt_vld && (gh.rd != '0);
   assign wb.reg_en  = wr;
   assign wb.reg_sel = wr ? gh.rd : '0;
   assign wb.wdat    = wr ? gh.wdat : '0;
   assign s_rw_en    = wb.reg_en;
   assign s_rw       = wb.reg_sel;

   always_ff @(posedge CLK) begin
      if (nRST) begin
         last_grant <= WB_JUMP;
         overflow   <= 1'b0;
      end else begin
         if (gnt_vld)
            last_grant <= gnt_src;
         if (|(push_v & full_v))
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter: grant order, speculation, flush,
// overflow, x0 handling and mid-run reset.
module tb_scalar_wb_arbiter;
   import datapath_pkg::*;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              alu_done, load_done, jump_done;
   logic [WORD_W-1:0] alu_wdat, load_wdat, jump_wdat;
   regbits_t          alu_reg_sel, load_reg_sel, jump_reg_sel;
   logic              spec, bfu_resolved, bfu_miss;
   logic              alu_rdy, load_rdy, jump_rdy, overflow, s_rw_en;
   wb_t               wb;
   regbits_t          s_rw;
   logic [43:0]       obs;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 CLK = ~CLK;

   scalar_wb_arbiter #(.DEPTH(2)) u_dut (
      .CLK(CLK), .nRST(nRST),
      .alu_done(alu_done), .load_done(load_done), .jump_done(jump_done),
      .alu_wdat(alu_wdat), .load_wdat(load_wdat), .jump_wdat(jump_wdat),
      .alu_reg_sel(alu_reg_sel), .load_reg_sel(load_reg_sel), .jump_reg_sel(jump_reg_sel),
      .spec(spec), .bfu_resolved(bfu_resolved), .bfu_miss(bfu_miss),
      .alu_rdy(alu_rdy), .load_rdy(load_rdy), .jump_rdy(jump_rdy),
      .wb(wb), .s_rw_en(s_rw_en), .s_rw(s_rw), .overflow(overflow)
   );

   assign obs = {wb.reg_en, wb.reg_sel, wb.wdat, s_rw_en, s_rw};

   function automatic logic [43:0] wexp(input regbits_t rd, input logic [31:0] d);
      return {1'b1, rd, d, 1'b1, rd};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr();
      {alu_done, load_done, jump_done, spec, bfu_resolved, bfu_miss} = '0;
      {alu_wdat, load_wdat, jump_wdat} = '0;
      {alu_reg_sel, load_reg_sel, jump_reg_sel} = '0;
   endtask

   task automatic do_reset();
      clr();
      nRST = 1'b1;
      tick();
      nRST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (obs !== 44'd0) $display("FAIL reset_wb: got %h want 0", obs); else n_pass++;
      n_chk++; if ({alu_rdy, load_rdy, jump_rdy, overflow} !== 4'b1110)
         $display("FAIL reset_rdy_ovf: got %b want 1110", {alu_rdy, load_rdy, jump_rdy, overflow}); else n_pass++;
   endtask

   task automatic test_single();
      alu_done = 1; alu_reg_sel = 5'd5; alu_wdat = 32'hDEAD_BEEF;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd5, 32'hDEAD_BEEF)) $display("FAIL single_wb: got %h want %h", obs, wexp(5'd5, 32'hDEAD_BEEF)); else n_pass++;
      tick();
      n_chk++; if (obs !== 44'd0) $display("FAIL single_drain: got %h want 0", obs); else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      alu_done = 1;  alu_reg_sel = 5'd1;  alu_wdat = 32'h11;
      load_done = 1; load_reg_sel = 5'd2; load_wdat = 32'h22;
      jump_done = 1; jump_reg_sel = 5'd3; jump_wdat = 32'h33;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd1, 32'h11)) $display("FAIL b2b_1: got %h want %h", obs, wexp(5'd1, 32'h11)); else n_pass++;
      tick();
      n_chk++; if (obs !== wexp(5'd2, 32'h22)) $display("FAIL b2b_2: got %h want %h", obs, wexp(5'd2, 32'h22)); else n_pass++;
      tick();
      n_chk++; if (obs !== wexp(5'd3, 32'h33)) $display("FAIL b2b_3: got %h want %h", obs, wexp(5'd3, 32'h33)); else n_pass++;
      tick();
      n_chk++; if (obs !== 44'd0) $display("FAIL b2b_idle: got %h want 0", obs); else n_pass++;
      // second burst: JUMP was last, so ALU leads again
      alu_done = 1;  alu_reg_sel = 5'd11;  alu_wdat = 32'hA1;
      load_done = 1; load_reg_sel = 5'd12; load_wdat = 32'hA2;
      jump_done = 1; jump_reg_sel = 5'd13; jump_wdat = 32'hA3;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd11, 32'hA1)) $display("FAIL b2b_burst2_first: got %h want %h", obs, wexp(5'd11, 32'hA1)); else n_pass++;
      tick(); tick();
      n_chk++; if (obs !== wexp(5'd13, 32'hA3)) $display("FAIL b2b_burst2_last: got %h want %h", obs, wexp(5'd13, 32'hA3)); else n_pass++;
      tick();
      alu_done = 1; alu_reg_sel = 5'd14; alu_wdat = 32'hB4;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd14, 32'hB4)) $display("FAIL b2b_alu_only: got %h want %h", obs, wexp(5'd14, 32'hB4)); else n_pass++;
      tick();
      // ALU was last: LOAD, JUMP, ALU
      alu_done = 1;  alu_reg_sel = 5'd21;  alu_wdat = 32'hC1;
      load_done = 1; load_reg_sel = 5'd22; load_wdat = 32'hC2;
      jump_done = 1; jump_reg_sel = 5'd23; jump_wdat = 32'hC3;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd22, 32'hC2)) $display("FAIL rr_load_first: got %h want %h", obs, wexp(5'd22, 32'hC2)); else n_pass++;
      tick();
      n_chk++; if (obs !== wexp(5'd23, 32'hC3)) $display("FAIL rr_jump_second: got %h want %h", obs, wexp(5'd23, 32'hC3)); else n_pass++;
      tick();
      n_chk++; if (obs !== wexp(5'd21, 32'hC1)) $display("FAIL rr_alu_third: got %h want %h", obs, wexp(5'd21, 32'hC1)); else n_pass++;
      tick();
   endtask

   task automatic test_spec();
      do_reset();
      load_done = 1; load_reg_sel = 5'd7; load_wdat = 32'h77; spec = 1;
      tick(); clr();
      alu_done = 1; alu_reg_sel = 5'd8; alu_wdat = 32'h88;
      n_chk++; if (obs !== 44'd0) $display("FAIL spec_held: got %h want 0", obs); else n_pass++;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd8, 32'h88)) $display("FAIL spec_other_drains: got %h want %h", obs, wexp(5'd8, 32'h88)); else n_pass++;
      tick();
      bfu_resolved = 1;
      n_chk++; if (obs !== 44'd0) $display("FAIL spec_still_held: got %h want 0", obs); else n_pass++;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd7, 32'h77)) $display("FAIL spec_resolved: got %h want %h", obs, wexp(5'd7, 32'h77)); else n_pass++;
      tick();
      load_done = 1; load_reg_sel = 5'd15; load_wdat = 32'h15; spec = 1; bfu_resolved = 1;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd15, 32'h15)) $display("FAIL spec_resolve_same_cycle: got %h want %h", obs, wexp(5'd15, 32'h15)); else n_pass++;
      tick();
   endtask

   task automatic test_miss();
      do_reset();
      alu_done = 1;  alu_reg_sel = 5'd16; alu_wdat = 32'h16;
      load_done = 1; load_reg_sel = 5'd4; load_wdat = 32'h44;
      jump_done = 1; jump_reg_sel = 5'd17; jump_wdat = 32'h17;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd16, 32'h16)) $display("FAIL miss_alu_first: got %h want %h", obs, wexp(5'd16, 32'h16)); else n_pass++;
      load_done = 1; load_reg_sel = 5'd9; load_wdat = 32'h99; spec = 1;
      tick(); clr();
      // load now holds rd4 then speculative rd9
      bfu_miss = 1;
      alu_done = 1; alu_reg_sel = 5'd10; alu_wdat = 32'h10; spec = 1;
      n_chk++; if (obs !== wexp(5'd4, 32'h44)) $display("FAIL miss_keep_nonspec: got %h want %h", obs, wexp(5'd4, 32'h44)); else n_pass++;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd17, 32'h17)) $display("FAIL miss_jump_next: got %h want %h", obs, wexp(5'd17, 32'h17)); else n_pass++;
      tick();
      n_chk++; if (obs !== 44'd0) $display("FAIL miss_idle: got %h want 0", obs); else n_pass++;
      // load must be empty: one spec push leaves it not full
      load_done = 1; load_reg_sel = 5'd24; load_wdat = 32'h24; spec = 1;
      tick(); clr();
      n_chk++; if (load_rdy !== 1'b1) $display("FAIL miss_load_count0: got rdy %b want 1", load_rdy); else n_pass++;
      load_done = 1; load_reg_sel = 5'd25; load_wdat = 32'h25; spec = 1;
      tick(); clr();
      n_chk++; if (load_rdy !== 1'b0) $display("FAIL miss_load_full: got rdy %b want 0", load_rdy); else n_pass++;
      bfu_miss = 1;
      tick(); clr();
      n_chk++; if ({load_rdy, alu_rdy} !== 2'b11) $display("FAIL miss_flush_rdy: got %b want 11", {load_rdy, alu_rdy}); else n_pass++;
      bfu_resolved = 1;
      tick(); clr();
      n_chk++; if (obs !== 44'd0) $display("FAIL miss_nothing_survives: got %h want 0", obs); else n_pass++;
      tick();
   endtask

   task automatic test_overflow();
      do_reset();
      jump_done = 1; jump_reg_sel = 5'd20; jump_wdat = 32'h20; spec = 1;
      tick(); clr();
      n_chk++; if (jump_rdy !== 1'b1) $display("FAIL ovf_rdy_one: got %b want 1", jump_rdy); else n_pass++;
      jump_done = 1; jump_reg_sel = 5'd21; jump_wdat = 32'h21; spec = 1;
      tick(); clr();
      n_chk++; if ({alu_rdy, load_rdy, jump_rdy, overflow} !== 4'b1100)
         $display("FAIL ovf_full: got %b want 1100", {alu_rdy, load_rdy, jump_rdy, overflow}); else n_pass++;
      jump_done = 1; jump_reg_sel = 5'd22; jump_wdat = 32'h22; spec = 1;
      tick(); clr();
      n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
      bfu_miss = 1;
      tick(); clr();
      n_chk++; if ({jump_rdy, overflow} !== 2'b11) $display("FAIL ovf_sticky_after_flush: got %b want 11", {jump_rdy, overflow}); else n_pass++;
      tick();
      n_chk++; if ({overflow, obs} !== {1'b1, 44'd0}) $display("FAIL ovf_sticky: got %h want %h", {overflow, obs}, {1'b1, 44'd0}); else n_pass++;
   endtask

   task automatic test_x0();
      do_reset();
      n_chk++; if (overflow !== 1'b0) $display("FAIL x0_ovf_cleared: got %b want 0", overflow); else n_pass++;
      alu_done = 1; alu_reg_sel = 5'd0; alu_wdat = 32'hFFFF_FFFF;
      tick(); clr();
      n_chk++; if (obs !== 44'd0) $display("FAIL x0_suppressed: got %h want 0", obs); else n_pass++;
      alu_done = 1; alu_reg_sel = 5'd6; alu_wdat = 32'h66;
      tick(); clr();
      n_chk++; if (obs !== wexp(5'd6, 32'h66)) $display("FAIL x0_consumed: got %h want %h", obs, wexp(5'd6, 32'h66)); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      alu_done = 1;  alu_reg_sel = 5'd1;  alu_wdat = 32'h1;
      load_done = 1; load_reg_sel = 5'd2; load_wdat = 32'h2;
      jump_done = 1; jump_reg_sel = 5'd3; jump_wdat = 32'h3;
      spec = 1;
      tick(); clr();
      // load and jump still queue speculative entries
      alu_done = 1; alu_reg_sel = 5'd5; alu_wdat = 32'h5;
      nRST = 1;
      tick(); clr();
      nRST = 0;
      n_chk++; if (obs !== 44'd0) $display("FAIL rstmid_wb: got %h want 0", obs); else n_pass++;
      n_chk++; if ({alu_rdy, load_rdy, jump_rdy, overflow} !== 4'b1110)
         $display("FAIL rstmid_rdy: got %b want 1110", {alu_rdy, load_rdy, jump_rdy, overflow}); else n_pass++;
      bfu_resolved = 1;
      tick(); clr();
      n_chk++; if (obs !== 44'd0) $display("FAIL rstmid_discarded: got %h want 0", obs); else n_pass++;
      tick();
      n_chk++; if (obs !== 44'd0) $display("FAIL rstmid_discarded2: got %h want 0", obs); else n_pass++;
   endtask

   initial begin
      nRST = 1'b1;
      clr();
      test_reset();
      test_single();
      test_back_to_back();
      test_spec();
      test_miss();
      test_overflow();
      test_x0();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
